// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller: default widths, the
// sequencer state encoding and the clamped step helpers.
package dds_ctrl_pkg;

  localparam int DEF_PAW     = 26;
  localparam int DEF_DWELL_W = 16;

  // Helpers work on 64-bit zero-extended operands so that one definition
  // serves any accumulator width up to 62 bits without losing the carry.
  localparam int HW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Upward step that never passes the stop word. A carry out of the
  // accumulator width always lands at or above stop, so it clamps too.
  function automatic logic [HW-1:0] clamp_add(input logic [HW-1:0] word,
                                              input logic [HW-1:0] step,
                                              input logic [HW-1:0] stop);
    logic [HW-1:0] sum;
    sum = word + step;
    if (step == '0 || sum >= stop) return stop;
    return sum;
  endfunction

  // Downward step that never passes the floor word; underflow clamps.
  function automatic logic [HW-1:0] clamp_sub(input logic [HW-1:0] word,
                                              input logic [HW-1:0] step,
                                              input logic [HW-1:0] floor);
    if (step == '0 || step > word) return floor;
    if (word - step <= floor) return floor;
    return word - step;
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host-side bundle of the sweep controller: configuration, start/abort
// handshake and the word/status outputs. master = host, slave = controller.
interface dds_sweep_ctrl_if
  import dds_ctrl_pkg::*;
#(
  parameter int PAW     = DEF_PAW,
  parameter int DWELL_W = DEF_DWELL_W
);
  logic               i_start;
  logic               i_abort;
  logic [PAW-1:0]     i_start_word;
  logic [PAW-1:0]     i_stop_word;
  logic [PAW-1:0]     i_step_word;
  logic [DWELL_W-1:0] i_dwell_cycles;
  logic               i_continuous;
  logic               i_triangle;
  logic [PAW-1:0]     o_dds_phase_accumulator_word;
  logic               o_step_strobe;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_abort, i_start_word, i_stop_word, i_step_word,
           i_dwell_cycles, i_continuous, i_triangle,
    input  o_dds_phase_accumulator_word, o_step_strobe, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_start_word, i_stop_word, i_step_word,
           i_dwell_cycles, i_continuous, i_triangle,
    output o_dds_phase_accumulator_word, o_step_strobe, o_busy, o_done
  );
endinterface

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter. A load of N starts a run whose expire pulse appears
// N cycles later on the combinational output (N=0 expires in the very next
// cycle), so the owner can load the next word on the same edge.
module dds_dwell_timer
  import dds_ctrl_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               clear,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;
  logic               active;

  assign expire = active && (cnt == '0);

  // Count down while active; stop after expiring unless reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (clear) begin
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the DDS phase accumulator word.
// Optional triangle (up/down) sweep is enabled by defining
// DDS_SWEEP_TRIANGLE_EN; without it only the sawtooth sweep exists.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int PAW     = DEF_PAW,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic            i_sys_clk,
  input  logic            i_sys_rst,
  dds_sweep_ctrl_if.slave bus
);

  state_t             state;
  logic [PAW-1:0]     word;
  logic [PAW-1:0]     lo_q;
  logic [PAW-1:0]     stop_q;
  logic [PAW-1:0]     step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic               strobe;
  logic               busy;
  logic               done;
`ifdef DDS_SWEEP_TRIANGLE_EN
  logic               tri_q;
`else
  logic               unused_triangle;
  assign unused_triangle = bus.i_triangle;
`endif

  logic               sweeping;
  logic               start_go;
  logic [PAW-1:0]     start_lo;
  logic [PAW-1:0]     up_next;
  logic [PAW-1:0]     dn_next;
  logic [DWELL_W-1:0] dwell_src;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_load;
  logic               tmr_expire;

  assign bus.o_dds_phase_accumulator_word = word;
  assign bus.o_step_strobe                = strobe;
  assign bus.o_busy                       = busy;
  assign bus.o_done                       = done;

  // Next-word candidates and dwell timer control.
  always_comb begin
    sweeping  = (state == UP) || (state == DOWN);
    start_go  = (state == IDLE) && bus.i_start && !bus.i_abort;
    // A start word above stop collapses the sweep onto the stop word.
    start_lo  = (bus.i_start_word < bus.i_stop_word) ? bus.i_start_word
                                                     : bus.i_stop_word;
    up_next   = PAW'(clamp_add(HW'(word), HW'(step_q), HW'(stop_q)));
    dn_next   = PAW'(clamp_sub(HW'(word), HW'(step_q), HW'(lo_q)));
    // The first load uses the live input; later reloads use the latched copy.
    dwell_src = (state == IDLE) ? bus.i_dwell_cycles : dwell_q;
    tmr_val   = (dwell_src == '0) ? '0 : dwell_src - 1'b1;
    tmr_load  = start_go || (sweeping && tmr_expire && !bus.i_abort);
  end

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (i_sys_clk),
    .rst      (i_sys_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .clear    (bus.i_abort),
    .expire   (tmr_expire)
  );

  // Sweep sequencer: state, latched configuration and registered outputs.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state   <= IDLE;
      word    <= '0;
      lo_q    <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      strobe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
      tri_q   <= 1'b0;
`endif
    end else begin
      strobe <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            lo_q    <= start_lo;
            stop_q  <= bus.i_stop_word;
            step_q  <= bus.i_step_word;
            dwell_q <= bus.i_dwell_cycles;
            cont_q  <= bus.i_continuous;
`ifdef DDS_SWEEP_TRIANGLE_EN
            tri_q   <= bus.i_triangle;
`endif
            word    <= start_lo;
            strobe  <= 1'b1;
            busy    <= 1'b1;
            state   <= UP;
          end
        end

        UP: begin
          if (bus.i_abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmr_expire) begin
            if (word == stop_q) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
              if (tri_q) begin
                word   <= dn_next;
                strobe <= 1'b1;
                state  <= DOWN;
              end else
`endif
              if (cont_q) begin
                word   <= lo_q;
                strobe <= 1'b1;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              word   <= up_next;
              strobe <= 1'b1;
            end
          end
        end

        DOWN: begin
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (bus.i_abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmr_expire) begin
            if (word == lo_q) begin
              if (cont_q) begin
                // Turn around without repeating the start word.
                word   <= up_next;
                strobe <= 1'b1;
                state  <= UP;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              word   <= dn_next;
              strobe <= 1'b1;
            end
          end
`else
          // Unreachable without the triangle option.
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: sweep sequences, clamping, continuous
// mode, abort, start-in-DONE, overflow and asynchronous reset.
module tb_dds_sweep_ctrl;

  localparam int PAW     = 26;
  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int unsigned exp_w [8];

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.PAW(PAW), .DWELL_W(DWELL_W)) bus ();

  dds_sweep_ctrl #(.PAW(PAW), .DWELL_W(DWELL_W)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input int unsigned s, input int unsigned e, input int unsigned st,
                             input int unsigned dw, input logic cont, input logic tri_sel);
    bus.i_start_word   = PAW'(s);
    bus.i_stop_word    = PAW'(e);
    bus.i_step_word    = PAW'(st);
    bus.i_dwell_cycles = DWELL_W'(dw);
    bus.i_continuous   = cont;
    bus.i_triangle     = tri_sel;
    bus.i_start        = 1'b1;
    tick();
    bus.i_start        = 1'b0;
    // Scramble configuration: the controller must use its latched copy.
    bus.i_start_word   = 26'h1555555;
    bus.i_stop_word    = '0;
    bus.i_step_word    = 26'd1;
    bus.i_dwell_cycles = 16'd7;
    bus.i_continuous   = ~cont;
    bus.i_triangle     = ~tri_sel;
  endtask

  task automatic run_words(input string tag, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < hold; d++) begin
        chk({tag, "_word"},   64'(bus.o_dds_phase_accumulator_word), 64'(exp_w[i]));
        chk({tag, "_strobe"}, 64'(bus.o_step_strobe), (d == 0) ? 64'd1 : 64'd0);
        chk({tag, "_busy"},   64'(bus.o_busy), 64'd1);
        chk({tag, "_done"},   64'(bus.o_done), 64'd0);
        tick();
      end
    end
  endtask

  task automatic expect_done(input string tag, input int unsigned w);
    chk({tag, "_done_pulse"}, 64'(bus.o_done), 64'd1);
    chk({tag, "_done_busy"},  64'(bus.o_busy), 64'd0);
    chk({tag, "_done_word"},  64'(bus.o_dds_phase_accumulator_word), 64'(w));
    chk({tag, "_done_strb"},  64'(bus.o_step_strobe), 64'd0);
    tick();
    chk({tag, "_idle_done"},  64'(bus.o_done), 64'd0);
    chk({tag, "_idle_busy"},  64'(bus.o_busy), 64'd0);
    chk({tag, "_idle_word"},  64'(bus.o_dds_phase_accumulator_word), 64'(w));
  endtask

  initial begin
    rst                = 1'b1;
    bus.i_start        = 1'b0;
    bus.i_abort        = 1'b0;
    bus.i_start_word   = '0;
    bus.i_stop_word    = '0;
    bus.i_step_word    = '0;
    bus.i_dwell_cycles = '0;
    bus.i_continuous   = 1'b0;
    bus.i_triangle     = 1'b0;
    tick();
    tick();
    chk("rst_word",   64'(bus.o_dds_phase_accumulator_word), 64'd0);
    chk("rst_strobe", 64'(bus.o_step_strobe), 64'd0);
    chk("rst_busy",   64'(bus.o_busy), 64'd0);
    chk("rst_done",   64'(bus.o_done), 64'd0);
    rst = 1'b0;
    tick();

    // Basic single-shot sweep, dwell 2
    start_sweep(100, 130, 10, 2, 1'b0, 1'b0);
    exp_w = '{100, 110, 120, 130, 0, 0, 0, 0};
    run_words("basic", 4, 2);
    expect_done("basic", 130);

    // Last step clamps to stop
    start_sweep(100, 125, 10, 1, 1'b0, 1'b0);
    exp_w = '{100, 110, 120, 125, 0, 0, 0, 0};
    run_words("clamp", 4, 1);
    expect_done("clamp", 125);

    // Dwell 0 behaves as 1
    start_sweep(0, 26844, 6711, 0, 1'b0, 1'b0);
    exp_w = '{0, 6711, 13422, 20133, 26844, 0, 0, 0};
    run_words("cb", 5, 1);
    expect_done("cb", 26844);

    // Continuous sweep, then abort mid-sweep
    start_sweep(0, 20, 10, 1, 1'b1, 1'b0);
    exp_w = '{0, 10, 20, 0, 10, 20, 0, 0};
    run_words("cont", 6, 1);
    chk("cont_pre_abort_word", 64'(bus.o_dds_phase_accumulator_word), 64'd0);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_busy",   64'(bus.o_busy), 64'd0);
    chk("abort_word",   64'(bus.o_dds_phase_accumulator_word), 64'd0);
    chk("abort_strobe", 64'(bus.o_step_strobe), 64'd0);
    chk("abort_done",   64'(bus.o_done), 64'd0);
    tick();
    chk("abort_done2",  64'(bus.o_done), 64'd0);
    chk("abort_busy2",  64'(bus.o_busy), 64'd0);

    // Run a short sweep to leave a nonzero word, then start+abort together
    start_sweep(70, 70, 5, 1, 1'b0, 1'b0);
    exp_w = '{70, 0, 0, 0, 0, 0, 0, 0};
    run_words("eq70", 1, 1);
    expect_done("eq70", 70);
    bus.i_start_word = 26'd5;
    bus.i_stop_word  = 26'd50;
    bus.i_step_word  = 26'd5;
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("sa_busy",   64'(bus.o_busy), 64'd0);
    chk("sa_strobe", 64'(bus.o_step_strobe), 64'd0);
    chk("sa_word",   64'(bus.o_dds_phase_accumulator_word), 64'd70);
    tick();
    chk("sa_busy2",  64'(bus.o_busy), 64'd0);

    // Step 0: start held one dwell, then stop
    start_sweep(40, 90, 0, 3, 1'b0, 1'b0);
    exp_w = '{40, 90, 0, 0, 0, 0, 0, 0};
    run_words("step0", 2, 3);
    expect_done("step0", 90);

    // start == stop, and a start pulse during DONE is ignored
    start_sweep(50, 50, 10, 2, 1'b0, 1'b0);
    exp_w = '{50, 0, 0, 0, 0, 0, 0, 0};
    run_words("eq50", 1, 2);
    chk("eq50_done", 64'(bus.o_done), 64'd1);
    chk("eq50_busy", 64'(bus.o_busy), 64'd0);
    bus.i_start_word = 26'd7;
    bus.i_stop_word  = 26'd9;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("startdone_busy",   64'(bus.o_busy), 64'd0);
    chk("startdone_strobe", 64'(bus.o_step_strobe), 64'd0);
    chk("startdone_word",   64'(bus.o_dds_phase_accumulator_word), 64'd50);
    tick();
    chk("startdone_busy2",  64'(bus.o_busy), 64'd0);

    // Start above stop collapses onto stop
    start_sweep(200, 150, 10, 1, 1'b0, 1'b0);
    exp_w = '{150, 0, 0, 0, 0, 0, 0, 0};
    run_words("rev", 1, 1);
    expect_done("rev", 150);

    // Overflow of the accumulator width clamps to stop
    start_sweep(67108859, 67108863, 8, 1, 1'b0, 1'b0);
    exp_w = '{67108859, 67108863, 0, 0, 0, 0, 0, 0};
    run_words("ovf", 2, 1);
    expect_done("ovf", 67108863);

`ifdef DDS_SWEEP_TRIANGLE_EN
    start_sweep(0, 20, 10, 1, 1'b0, 1'b1);
    exp_w = '{0, 10, 20, 10, 0, 0, 0, 0};
    run_words("tri", 5, 1);
    expect_done("tri", 0);
`endif

    // Asynchronous reset mid-sweep, asserted away from any clock edge
    start_sweep(500, 1000, 1, 5, 1'b0, 1'b0);
    tick();
    chk("ar_pre_word", 64'(bus.o_dds_phase_accumulator_word), 64'd500);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_word",   64'(bus.o_dds_phase_accumulator_word), 64'd0);
    chk("ar_busy",   64'(bus.o_busy), 64'd0);
    chk("ar_strobe", 64'(bus.o_step_strobe), 64'd0);
    chk("ar_done",   64'(bus.o_done), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_after_busy", 64'(bus.o_busy), 64'd0);
    chk("ar_after_word", 64'(bus.o_dds_phase_accumulator_word), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer for the DDS core. Drives its 26-bit phase accumulator control word through a programmed linear sweep from start to stop. Each word is held for a programmable number of clock cycles. Sits between the host/config registers and the DDS input i_dds_phase_accumulator_word. Supports single-shot or continuous sweeps, with start/abort/busy/done handshakes.

Parameters:
PAW, 26, phase accumulator word width (must match the DDS).
DWELL_W, 16, width of the dwell-cycle count.

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge
i_sys_rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle start pulse; ignored while o_busy=1
i_abort  in  1  stop the sweep immediately; wins over i_start
i_start_word  in  PAW  first control word
i_stop_word  in  PAW  final control word (sweep upper bound)
i_step_word  in  PAW  increment per step
i_dwell_cycles  in  DWELL_W  cycles each word is held; 0 is treated as 1
i_continuous  in  1  1 = restart at start word after completion
i_triangle  in  1  up/down sweep select; used only with the macro
o_dds_phase_accumulator_word  out  PAW  word to the DDS
o_step_strobe  out  1  one-cycle pulse on every cycle a new word is loaded
o_busy  out  1  high while sweeping
o_done  out  1  one-cycle pulse when a single-shot sweep completes

Behaviour:
- Reset: all outputs 0; state IDLE; config registers 0.
- States: IDLE, UP, DOWN (DOWN exists only with the macro), DONE.
- IDLE + i_start (no abort) at cycle N:
  - latch all i_* config inputs;
  - at N+1: word = min(start, stop), o_step_strobe=1, o_busy=1, state UP, dwell counter loaded.
- Config inputs are don't-care outside the i_start cycle.
- Dwell: each word is held exactly max(i_dwell_cycles,1) cycles, counted from its strobe cycle.
- UP step at dwell expiry:
  - next = word + step, computed in PAW+1 bits;
  - if step==0, or next[PAW]=1, or next >= stop: word = stop (clamp);
  - otherwise word = next;
  - strobe with every load.
- Stop word's dwell expires:
  - continuous: reload start word (strobe), stay busy;
  - single-shot: go to DONE.
- DONE: o_done=1 and o_busy=0 for one cycle, then IDLE. The word holds stop.
- i_start during DONE is ignored.
- i_abort in any non-IDLE state: next cycle IDLE, o_busy=0, no o_done, word holds its current value.
- i_abort in IDLE: no effect.
- A word is never outside [min(start,stop), stop]. There is no wrap-around.
- Reset mid-sweep: immediate return to the reset values.

Optional Feature:
DDS_SWEEP_TRIANGLE_EN
- Defined, i_triangle=1 (latched at start): after the stop word's dwell, enter DOWN.
  - Step: word = word - step, clamped at the start word; the step-0 or underflow condition also clamps.
  - After the start word's dwell: continuous → UP with the next word start+step (no repeat of start); single-shot → DONE.
- Defined, i_triangle=0: sawtooth behaviour, as without the macro.
- Undefined: i_triangle ignored, DOWN state absent, sawtooth only.

Decomposition:
- Shared package dds_ctrl_pkg holds:
  - PAW default 26;
  - state enum {IDLE, UP, DOWN, DONE};
  - the clamp-add/clamp-sub helper functions.
- One natural sub-module, dds_dwell_timer: a load/expire down-counter of DWELL_W bits with a 1-cycle expire pulse. Everything else stays in dds_sweep_ctrl.

Test Plan:
- start=100, stop=130, step=10, dwell=2, single-shot, start pulse at cycle 0:
  - words 100,110,120,130, each held 2 cycles, from cycle 1;
  - strobes at cycles 1,3,5,7; o_done at cycle 9 with o_busy=0.
- Clamp: start=100, stop=125, step=10, dwell=1 → 100,110,120,125, then done.
- Codebase step: start=0, stop=26844, step=6711, dwell=0 (treated as 1) → 0,6711,13422,20133,26844 on consecutive cycles.
- Continuous: start=0, stop=20, step=10, dwell=1 → 0,10,20,0,10,… with no o_done.
  - i_abort mid-sweep → o_busy low next cycle, word frozen, no done.
  - i_start+i_abort in the same IDLE cycle → stays IDLE.
- Edges:
  - step=0 → start held one dwell, then stop;
  - start=stop=50 → single word 50, then done;
  - overflow: start=2^26-5, stop=2^26-1, step=8 → clamps to 2^26-1;
  - async reset mid-sweep → all outputs 0 without waiting for a clock edge.
- With DDS_SWEEP_TRIANGLE_EN, triangle=1, start=0, stop=20, step=10, dwell=1, single-shot → 0,10,20,10,0, then done.
